mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 16, address width; DATA_W, 32, data width; TO_CYC, 255, timeout limit in cycles (TO_CYC >= 1).
REQ-002 CLK  in  1  sole clock, all state updates on posedge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 IF_REQ  in  1  instruction-fetch read request; held with IF_ADDR stable until IF_VALID.
REQ-005 IF_ADDR  in  ADDR_W  fetch address.
REQ-006 IF_GNT  out  1  one-cycle pulse: fetch accepted.
REQ-007 IF_VALID  out  1  one-cycle pulse: IF_RDATA valid, fetch complete.
REQ-008 IF_RDATA  out  DATA_W  fetched word.
REQ-009 DM_REQ  in  1  data request; held with DM_WE/DM_ADDR/DM_WDATA stable until DM_VALID.
REQ-010 DM_WE  in  1  1 = write, 0 = read.
REQ-011 DM_ADDR  in  ADDR_W  data address.
REQ-012 DM_WDATA  in  DATA_W  write data.
REQ-013 DM_GNT  out  1  one-cycle pulse: data access accepted.
REQ-014 DM_VALID  out  1  one-cycle pulse: access complete (read data valid, or write acknowledged).
REQ-015 DM_RDATA  out  DATA_W  read word.
REQ-016 MEM_EN  out  1  memory access active.
REQ-017 MEM_WE  out  1  memory write strobe.
REQ-018 MEM_ADDR  out  ADDR_W  memory address.
REQ-019 MEM_WDATA  out  DATA_W  memory write data.
REQ-020 MEM_RDATA  in  DATA_W  memory read data, valid with MEM_READY.
REQ-021 MEM_READY  in  1  memory completes current access this cycle.
REQ-022 ERR  out  1  one-cycle pulse: access aborted by timeout.

Function
REQ-023 FSM states: IDLE, BUSY_IF, BUSY_DM, DONE; all outputs registered.
REQ-024 IDLE: only DM_REQ -> BUSY_DM; only IF_REQ -> BUSY_IF; none -> stay IDLE.
REQ-025 Both requests in IDLE: round-robin; grant the port not granted last; LAST pointer updated on every grant.
REQ-026 On IDLE->BUSY_x: GNT of that port pulses 1 cycle; MEM_EN=1, MEM_ADDR/MEM_WE/MEM_WDATA latched from requester (MEM_WE=DM_WE for DM, 0 for IF) and held constant through BUSY_x.
REQ-027 BUSY_x with MEM_READY=1: capture MEM_RDATA into x_RDATA (reads only), MEM_EN=0, MEM_WE=0 next cycle, x_VALID pulses next cycle, go to DONE.
REQ-028 BUSY_x with MEM_READY=0: stay, outputs unchanged.
REQ-029 DONE -> IDLE unconditionally (one bubble, so a requester sees VALID before rearbitration).
REQ-030 Minimum latency: REQ sampled at edge k -> GNT and MEM_EN high after k+1 -> VALID high after k+2 if MEM_READY at k+1..k+2 -> next grant after k+4.
REQ-031 DM write: DM_RDATA unchanged; DM_VALID still pulses.
REQ-032 x_RDATA holds last value until next completed read on that port.
REQ-033 MEM_READY in IDLE or DONE: ignored.
REQ-034 Request dropped while in BUSY: illegal per protocol; access still completes and VALID still pulses.
REQ-035 GNT, VALID, ERR never high in the same cycle for both ports.

Reset
REQ-036 RST_N=0 forces immediately: state IDLE, LAST=DM (IF wins first tie), all outputs 0, RDATA registers 0, timeout counter 0.
REQ-037 Reset mid-access: access abandoned, no VALID/ERR after release; first grant no earlier than one edge after RST_N rises.

Configuration
REQ-038 Macro MEM_ARBITER_TIMEOUT_EN defined: counter clears on BUSY entry, increments each BUSY cycle with MEM_READY=0; at count TO_CYC -> ERR pulse, x_VALID pulse with RDATA unchanged, MEM_EN=0, go to DONE.
REQ-039 Macro undefined: no counter, ERR tied 0, BUSY waits indefinitely.

Verification
REQ-040 IF_REQ=1 IF_ADDR=0x0010, MEM_READY=1 always, MEM_RDATA=0xDEADBEEF -> IF_GNT one cycle, MEM_ADDR=0x0010 MEM_WE=0, IF_VALID next cycle with IF_RDATA=0xDEADBEEF.
REQ-041 IF_REQ and DM_REQ asserted together after reset -> IF granted first, then DM; repeated held requests alternate IF,DM,IF,DM.
REQ-042 DM write DM_ADDR=0x0200 DM_WDATA=0x12345678, MEM_READY delayed 3 cycles -> MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA stable 4 cycles, DM_VALID once, DM_RDATA unchanged.
REQ-043 RST_N pulsed low in BUSY_DM -> all outputs 0 asynchronously, no DM_VALID afterward, IDLE on release.
REQ-044 With MEM_ARBITER_TIMEOUT_EN, TO_CYC=4, MEM_READY held 0 -> ERR and IF_VALID pulse after 4 BUSY cycles; without macro, MEM_EN stays 1 for 100+ cycles, ERR=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // Requests are level handshakes: a requester raises REQ with its fields
    // stable, sees a one-cycle GNT on acceptance, and holds until its one-cycle
    // VALID; MEM_READY completes the active memory access in that cycle.
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_VALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              DM_REQ;
    logic              DM_WE;
    logic [ADDR_W-1:0] DM_ADDR;
    logic [DATA_W-1:0] DM_WDATA;
    logic              DM_GNT;
    logic              DM_VALID;
    logic [DATA_W-1:0] DM_RDATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              MEM_READY;

    logic              ERR;

    modport slave (
        input  IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA, MEM_RDATA, MEM_READY,
        output IF_GNT, IF_VALID, IF_RDATA, DM_GNT, DM_VALID, DM_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, ERR
    );

    modport master (
        output IF_REQ, IF_ADDR, DM_REQ, DM_WE, DM_ADDR, DM_WDATA, MEM_RDATA, MEM_READY,
        input  IF_GNT, IF_VALID, IF_RDATA, DM_GNT, DM_VALID, DM_RDATA,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, ERR
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data.
// Define MEM_ARBITER_TIMEOUT_EN to abort accesses that wait TO_CYC cycles for MEM_READY.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 255
) (
    input  logic         CLK,
    input  logic         RST_N,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_dm_q, last_dm_d;
    logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              grant_if, grant_dm, busy, to_hit;

    // Fetch wins a tie unless it was the last one served.
    assign grant_if = bus.IF_REQ && (!bus.DM_REQ || last_dm_q);
    assign grant_dm = bus.DM_REQ && !grant_if;
    assign busy     = (state_q == S_BUSY_IF) || (state_q == S_BUSY_DM);

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_IDLE)           to_cnt_d = '0;
        else if (busy && !bus.MEM_READY) to_cnt_d = to_cnt_q + 1'b1;
    end

    assign to_hit = busy && !bus.MEM_READY && (to_cnt_q == CNT_W'(TO_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    // State and every output are registered together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            last_dm_q   <= 1'b1;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_if)      state_d = S_BUSY_IF;
                else if (grant_dm) state_d = S_BUSY_DM;
            end
            S_BUSY_IF, S_BUSY_DM: begin
                if (bus.MEM_READY || to_hit) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = 1'b0;
        last_dm_d   = last_dm_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_if) begin
                    if_gnt_d    = 1'b1;
                    last_dm_d   = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.IF_ADDR;
                    mem_wdata_d = '0;
                end else if (grant_dm) begin
                    dm_gnt_d    = 1'b1;
                    last_dm_d   = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.DM_WE;
                    mem_addr_d  = bus.DM_ADDR;
                    mem_wdata_d = bus.DM_WDATA;
                end
            end
            S_BUSY_IF: begin
                if (bus.MEM_READY || to_hit) begin
                    if_valid_d = 1'b1;
                    err_d      = !bus.MEM_READY;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    if (bus.MEM_READY) if_rdata_d = bus.MEM_RDATA;
                end
            end
            S_BUSY_DM: begin
                if (bus.MEM_READY || to_hit) begin
                    dm_valid_d = 1'b1;
                    err_d      = !bus.MEM_READY;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    // Writes leave the last read word visible.
                    if (bus.MEM_READY && !mem_we_q) dm_rdata_d = bus.MEM_RDATA;
                end
            end
            default: ;
        endcase
    end

    assign bus.IF_GNT    = if_gnt_q;
    assign bus.IF_VALID  = if_valid_q;
    assign bus.IF_RDATA  = if_rdata_q;
    assign bus.DM_GNT    = dm_gnt_q;
    assign bus.DM_VALID  = dm_valid_q;
    assign bus.DM_RDATA  = dm_rdata_q;
    assign bus.MEM_EN    = mem_en_q;
    assign bus.MEM_WE    = mem_we_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign bus.ERR       = err_q;
    assign dbg_state     = state_q;

endmodule
